// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
//
// Store path between the execute stage and the data-memory bus. One store
// request is accepted per valid/ready handshake. The unit right-aligns nothing
// itself: the caller supplies right-justified data, and the unit shifts it into
// the correct byte lanes of an XLEN-bit bus and generates matching byte strobes.
// A misaligned store that crosses a bus word is split into two bus beats, each
// with its own mem_valid/mem_ready handshake. It can instead be rejected with a
// fault pulse, depending on ALLOW_MISALIGNED.
//
// Parameters
//   XLEN             datapath / bus width, 32 or 64 (NB = XLEN/8 lanes)
//   ADDR_W           byte-address width
//   ALLOW_MISALIGNED 1 = split crossing stores into two beats, 0 = fault on any
//                    misaligned store
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   store request valid
//   req_ready  out  unit is idle and can take a request
//   req_addr   in   byte address
//   req_data   in   store data, right-justified
//   req_type   in   access size: 0=B, 1=H, 2=W, 3=D (D only when XLEN=64)
//   mem_valid  out  bus beat valid
//   mem_ready  in   bus accepts the beat
//   mem_addr   out  beat address, aligned to NB
//   mem_wdata  out  beat data, unstrobed lanes are zero
//   mem_wstrb  out  byte-lane strobes
//   done       out  one-cycle pulse when the store is fully written
//   fault      out  one-cycle pulse for a rejected store (no beats issued)
// -----------------------------------------------------------------------------
module store_unit #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_data,
  input  logic [1:0]          req_type,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  output logic                done,
  output logic                fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam bit IS_32 = (XLEN == 32);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful while a request is being accepted)
  // ---------------------------------------------------------------------------
  logic [OFF_W-1:0]   off;
  logic [XLEN-1:0]    data_mask;
  logic [NB-1:0]      size_strb;
  logic [2*XLEN-1:0]  data_shift;
  logic [2*NB-1:0]    strb_shift;
  logic [ADDR_W-1:0]  addr_aligned;
  logic               misaligned;
  logic               illegal;
  logic               reject;
  logic               accept;

  assign off          = req_addr[OFF_W-1:0];
  assign addr_aligned = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Size-dependent data mask, strobe pattern and alignment test.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    data_mask  = '0;
    size_strb  = '0;
    misaligned = 1'b0;
    case (req_type)
      2'd0: begin
        data_mask[7:0] = '1;
        size_strb[0]   = 1'b1;
      end
      2'd1: begin
        data_mask[15:0] = '1;
        size_strb[1:0]  = '1;
        misaligned      = req_addr[0];
      end
      2'd2: begin
        data_mask[31:0] = '1;
        size_strb[3:0]  = '1;
        misaligned      = |req_addr[1:0];
      end
      default: begin
        // Doubleword: only reachable as a legal access on a 64-bit datapath.
        data_mask  = '1;
        size_strb  = '1;
        misaligned = |req_addr[2:0];
      end
    endcase
  end

  // The double-width shift lets a crossing store spill into the upper half,
  // which becomes the second beat.
  assign data_shift = {{XLEN{1'b0}}, req_data & data_mask} << {off, 3'b000};
  assign strb_shift = {{NB{1'b0}}, size_strb} << off;

  assign illegal = IS_32 && (req_type == 2'd3);
  assign reject  = illegal || (misaligned && (ALLOW_MISALIGNED == 0));
  assign accept  = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Beat registers
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] beat_addr;
  logic [XLEN-1:0]   beat_data;
  logic [NB-1:0]     beat_strb;
  logic [XLEN-1:0]   hi_data;
  logic [NB-1:0]     hi_strb;
  logic              done_q;
  logic              fault_q;
  logic              beat0_hs;
  logic              split;
  logic              last_hs;

  assign beat0_hs = (state == BEAT0) && mem_ready;
  assign split    = (hi_strb != '0);
  // The handshake that completes the store: a single-beat BEAT0 or any BEAT1.
  assign last_hs  = (beat0_hs && !split) || ((state == BEAT1) && mem_ready);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples values from before the edge, regardless of block order.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && !reject) begin
          state_nxt = BEAT0;
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          state_nxt = split ? BEAT1 : IDLE;
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the beat payload registers are reset as well, so the bus outputs
    // read zero out of reset instead of power-up garbage.
    if (rst) begin
      beat_addr <= '0;
      beat_data <= '0;
      beat_strb <= '0;
      hi_data   <= '0;
      hi_strb   <= '0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      done_q  <= last_hs;
      fault_q <= accept && reject;
      if (accept && !reject) begin
        beat_addr <= addr_aligned;
        beat_data <= data_shift[XLEN-1:0];
        beat_strb <= strb_shift[NB-1:0];
        hi_data   <= data_shift[2*XLEN-1:XLEN];
        hi_strb   <= strb_shift[2*NB-1:NB];
      end else if (beat0_hs && split) begin
        // Second beat goes to the next bus word; the add wraps at 2^ADDR_W.
        beat_addr <= beat_addr + ADDR_W'(NB);
        beat_data <= hi_data;
        beat_strb <= hi_strb;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = (state == IDLE) && !rst;
    mem_valid = (state != IDLE);
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (mem_valid) begin
      mem_addr  = beat_addr;
      mem_wdata = beat_data;
      mem_wstrb = beat_strb;
    end
    done  = done_q;
    fault = fault_q;
  end

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
//
// Three instances of store_unit share one request bus and one mem_ready:
//   dut 0: XLEN=32, misaligned stores split
//   dut 1: XLEN=32, misaligned stores fault
//   dut 2: XLEN=64, misaligned stores split
// Only one instance is driven at a time (per-instance req_valid). Stimulus
// pushes expected beats and done/fault events into queues; a monitor pops and
// compares whenever an instance completes a beat or pulses done/fault.
// -----------------------------------------------------------------------------
module tb_store_unit;

  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } beat_t;

  typedef struct {
    int   dut;
    logic is_fault;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_type;
  logic        mem_ready;
  logic [2:0]  mem_valid;
  logic [2:0]  done;
  logic [2:0]  fault;

  logic [31:0] ma0, ma1, ma2;
  logic [31:0] wd0, wd1;
  logic [63:0] wd2;
  logic [3:0]  ws0, ws1;
  logic [7:0]  ws2;

  logic [31:0] m_addr [3];
  logic [63:0] m_data [3];
  logic [7:0]  m_strb [3];

  assign m_addr[0] = ma0;
  assign m_addr[1] = ma1;
  assign m_addr[2] = ma2;
  assign m_data[0] = {32'b0, wd0};
  assign m_data[1] = {32'b0, wd1};
  assign m_data[2] = wd2;
  assign m_strb[0] = {4'b0, ws0};
  assign m_strb[1] = {4'b0, ws1};
  assign m_strb[2] = ws2;

  always #5 clk = ~clk;

  store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_s32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr), .req_data(req_data[31:0]), .req_type(req_type),
    .mem_valid(mem_valid[0]), .mem_ready(mem_ready),
    .mem_addr(ma0), .mem_wdata(wd0), .mem_wstrb(ws0),
    .done(done[0]), .fault(fault[0])
  );

  store_unit #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) u_f32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr), .req_data(req_data[31:0]), .req_type(req_type),
    .mem_valid(mem_valid[1]), .mem_ready(mem_ready),
    .mem_addr(ma1), .mem_wdata(wd1), .mem_wstrb(ws1),
    .done(done[1]), .fault(fault[1])
  );

  store_unit #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1)) u_s64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr), .req_data(req_data), .req_type(req_type),
    .mem_valid(mem_valid[2]), .mem_ready(mem_ready),
    .mem_addr(ma2), .mem_wdata(wd2), .mem_wstrb(ws2),
    .done(done[2]), .fault(fault[2])
  );

  int    total = 0;
  int    bad   = 0;
  beat_t beat_q[$];
  ev_t   ev_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event expected none at %0t", name, $time);
  endtask

  task automatic exp_beat(input int dut, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s);
    beat_t b;
    b.dut  = dut;
    b.addr = a;
    b.data = d;
    b.strb = s;
    beat_q.push_back(b);
  endtask

  task automatic exp_ev(input int dut, input logic is_fault);
    ev_t e;
    e.dut      = dut;
    e.is_fault = is_fault;
    ev_q.push_back(e);
  endtask

  // Issue one request on instance sel; returns #1 after the accepting edge.
  task automatic send(input int sel, input logic [31:0] a, input logic [63:0] d,
                      input logic [1:0] t);
    int n = 0;
    while (!req_ready[sel]) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        note_fail("send_timeout");
        return;
      end
    end
    req_addr       = a;
    req_data       = d;
    req_type       = t;
    req_valid[sel] = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    beat_t b;
    ev_t   e;
    for (int i = 0; i < 3; i++) begin
      if (mem_valid[i] && mem_ready) begin
        if (beat_q.size() == 0) begin
          note_fail("beat_unexpected");
        end else begin
          b = beat_q.pop_front();
          check("beat_dut",  64'(i), 64'(b.dut));
          check("beat_addr", 64'(m_addr[i]), 64'(b.addr));
          check("beat_data", m_data[i], b.data);
          check("beat_strb", 64'(m_strb[i]), 64'(b.strb));
        end
      end
      if (done[i] || fault[i]) begin
        check("done_fault_excl", 64'(done[i] & fault[i]), 64'd0);
        if (ev_q.size() == 0) begin
          note_fail("event_unexpected");
        end else begin
          e = ev_q.pop_front();
          check("event_dut",  64'(i), 64'(e.dut));
          check("event_kind", 64'(fault[i]), 64'(e.is_fault));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dcnt;
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_type  = '0;
    mem_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_done",      64'(done), 64'd0);
    check("rst_fault",     64'(fault), 64'd0);
    check("rst_addr",      64'(ma0), 64'd0);
    check("rst_wdata",     wd2, 64'd0);
    check("rst_wstrb",     64'(ws2), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rel_req_ready", 64'(req_ready), 64'h7);

    // SB 0x1003: single beat, done two cycles after accept.
    exp_beat(0, 32'h1000, 64'hDD000000, 8'h8);
    exp_ev(0, 1'b0);
    send(0, 32'h1003, 64'hAABBCCDD, 2'd0);
    @(negedge clk);
    check("sb_valid_n1", 64'(mem_valid[0]), 64'd1);
    @(negedge clk);
    check("sb_done_n2",  64'(done[0]), 64'd1);
    check("sb_ready_n2", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;

    // SW 0x2000 with the bus stalling for three cycles.
    mem_ready = 1'b0;
    exp_beat(0, 32'h2000, 64'h11223344, 8'hF);
    exp_ev(0, 1'b0);
    send(0, 32'h2000, 64'h11223344, 2'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(mem_valid[0]), 64'd1);
      check("stall_addr",  64'(ma0), 64'h2000);
      check("stall_wdata", 64'(wd0), 64'h11223344);
      check("stall_wstrb", 64'(ws0), 64'hF);
      check("stall_ready", 64'(req_ready[0]), 64'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("stall_valid_hs", 64'(mem_valid[0]), 64'd1);
        check("stall_ready_hs", 64'(req_ready[0]), 64'd0);
      end
      dcnt += int'(done[0]);
    end
    check("stall_one_done", 64'(dcnt), 64'd1);
    @(posedge clk); #1;

    // SW 0x2002: crossing store split in two, done after the second beat.
    exp_beat(0, 32'h2000, 64'h33440000, 8'hC);
    exp_beat(0, 32'h2004, 64'h00001122, 8'h3);
    exp_ev(0, 1'b0);
    send(0, 32'h2002, 64'h11223344, 2'd2);
    @(negedge clk);
    check("split_b0_addr", 64'(ma0), 64'h2000);
    @(negedge clk);
    check("split_b1_valid", 64'(mem_valid[0]), 64'd1);
    check("split_b1_addr",  64'(ma0), 64'h2004);
    check("split_no_early_done", 64'(done[0]), 64'd0);
    @(negedge clk);
    check("split_done_n3", 64'(done[0]), 64'd1);
    @(posedge clk); #1;

    // SH 0xFFFFFFFF: second beat address wraps to zero.
    exp_beat(0, 32'hFFFFFFFC, 64'hEF000000, 8'h8);
    exp_beat(0, 32'h00000000, 64'h000000BE, 8'h1);
    exp_ev(0, 1'b0);
    send(0, 32'hFFFFFFFF, 64'hBEEF, 2'd1);

    // Aligned SH, misaligned but non-crossing SH, SB in lane 1.
    exp_beat(0, 32'h1000, 64'h56780000, 8'hC);
    exp_ev(0, 1'b0);
    send(0, 32'h1002, 64'h12345678, 2'd1);
    exp_beat(0, 32'h2000, 64'h00BEEF00, 8'h6);
    exp_ev(0, 1'b0);
    send(0, 32'h2001, 64'hBEEF, 2'd1);
    exp_beat(0, 32'h1000, 64'h00005A00, 8'h2);
    exp_ev(0, 1'b0);
    send(0, 32'h1001, 64'hFFFFFF5A, 2'd0);

    // Doubleword on a 32-bit datapath is illegal even with splitting enabled.
    exp_ev(0, 1'b1);
    send(0, 32'h1000, 64'h0, 2'd3);
    @(negedge clk);
    check("illegal_fault",    64'(fault[0]), 64'd1);
    check("illegal_no_valid", 64'(mem_valid[0]), 64'd0);
    @(negedge clk);
    check("illegal_fault_1cyc", 64'(fault[0]), 64'd0);
    check("illegal_no_done",    64'(done[0]), 64'd0);
    check("illegal_ready",      64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;

    // Fault policy instance.
    exp_ev(1, 1'b1);
    send(1, 32'h2001, 64'h11223344, 2'd2);
    @(negedge clk);
    check("mis_fault",    64'(fault[1]), 64'd1);
    check("mis_no_valid", 64'(mem_valid[1]), 64'd0);
    @(negedge clk);
    check("mis_no_done",   64'(done[1]), 64'd0);
    check("mis_no_valid2", 64'(mem_valid[1]), 64'd0);
    @(posedge clk); #1;
    exp_ev(1, 1'b1);
    send(1, 32'h3001, 64'hBEEF, 2'd1);
    exp_ev(1, 1'b1);
    send(1, 32'h3000, 64'h0, 2'd3);
    exp_beat(1, 32'h3000, 64'h56780000, 8'hC);
    exp_ev(1, 1'b0);
    send(1, 32'h3002, 64'h12345678, 2'd1);
    exp_beat(1, 32'h3000, 64'h00007800, 8'h2);
    exp_ev(1, 1'b0);
    send(1, 32'h3001, 64'h12345678, 2'd0);

    // 64-bit SD, single beat with all lanes.
    exp_beat(2, 32'h8, 64'h0102030405060708, 8'hFF);
    exp_ev(2, 1'b0);
    send(2, 32'h8, 64'h0102030405060708, 2'd3);
    @(negedge clk);
    check("sd_wstrb", 64'(ws2), 64'hFF);
    @(negedge clk);
    check("sd_done", 64'(done[2]), 64'd1);
    @(posedge clk); #1;

    // 64-bit crossing SW, reset while the second beat is pending.
    exp_beat(2, 32'h0, 64'h3344000000000000, 8'hC0);
    send(2, 32'h6, 64'h11223344, 2'd2);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("b1_valid", 64'(mem_valid[2]), 64'd1);
    check("b1_addr",  64'(ma2), 64'h8);
    check("b1_strb",  64'(ws2), 64'h03);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(mem_valid[2]), 64'd0);
    check("rst_mid_ready", 64'(req_ready[2]), 64'd0);
    @(negedge clk) rst = 1'b0;
    #1;
    check("rst_rel_ready", 64'(req_ready[2]), 64'd1);
    mem_ready = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dcnt += int'(done[2]) + int'(mem_valid[2]);
    end
    check("rst_no_done_no_beat", 64'(dcnt), 64'd0);

    // Drain the scoreboard.
    n = 0;
    while ((beat_q.size() != 0 || ev_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_beats",  64'(beat_q.size()), 64'd0);
    check("drain_events", 64'(ev_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
Sequential store path between the execute stage and the data-memory bus.
- Takes one store request per valid/ready handshake.
- Aligns the data and generates byte strobes for a bus of XLEN bits.
- Splits a misaligned store that crosses a bus word into two bus beats, each with its own handshake.
- Parametrised for a 32- or 64-bit datapath and for misaligned-access policy (split or fault).

Parameters:
XLEN, 32, datapath and bus width; only 32 or 64 is legal; NB = XLEN/8 bytes per beat.
ADDR_W, 32, byte-address width.
ALLOW_MISALIGNED, 1, 1 = split a crossing store into two beats; 0 = fault on any misaligned store.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
req_valid  in  1  store request valid.
req_ready  out  1  unit can accept a request.
req_addr  in  ADDR_W  byte address.
req_data  in  XLEN  store data, right-justified.
req_type  in  2  0=B, 1=H, 2=W, 3=D (D is legal only when XLEN=64).
mem_valid  out  1  bus beat valid.
mem_ready  in  1  bus accepts the beat.
mem_addr  out  ADDR_W  beat address, aligned to NB.
mem_wdata  out  XLEN  beat data; lanes without a strobe are zero.
mem_wstrb  out  NB  byte-lane strobes.
done  out  1  one-cycle pulse: store fully written.
fault  out  1  one-cycle pulse: misaligned (when ALLOW_MISALIGNED=0) or illegal type; no beats are issued.

Behaviour:
- Reset (asynchronous): state=IDLE.
  - mem_valid, mem_addr, mem_wdata, mem_wstrb, done and fault are all 0.
  - req_ready = (state==IDLE) & ~rst.
- FSM states: IDLE, BEAT0, BEAT1.
- Accept: req_valid & req_ready in IDLE.
  - Compute off = addr mod NB and size = 1<<req_type.
  - Compute a 2*XLEN shifted data value = req_data[8*size-1:0] << 8*off.
  - Compute a 2*NB strobe = ((1<<size)-1) << off.
  - misaligned = (addr mod size) != 0.
  - illegal = (req_type==3 && XLEN==32).
- Accept with illegal, or with misaligned && !ALLOW_MISALIGNED:
  - Stay in IDLE and register fault=1 for the next cycle.
  - No mem_valid is issued and done is not asserted.
- Accept otherwise:
  - Register the low halves as beat 0: mem_addr = addr & ~(NB-1).
  - Hold the high halves for beat 1.
  - Go to BEAT0; mem_valid rises in the cycle after accept.
- BEAT0/BEAT1: mem_valid stays high and mem_addr/wdata/wstrb stay stable until mem_ready.
  - On the handshake in BEAT0: if the high strobe half is nonzero, go to BEAT1 with mem_addr = beat0 addr + NB (wraps modulo 2^ADDR_W), mem_valid staying high. Otherwise go to IDLE.
  - On the handshake in BEAT1: go to IDLE.
  - On the final handshake: register done=1 for one cycle and set mem_valid=0.
- Latency with mem_ready tied high:
  - Accept at cycle N, beat0 at N+1, done at N+2 (single beat) or N+3 (split).
  - req_ready is high again at N+2 / N+3.
  - Throughput for aligned stores: one store per 2 cycles.
- req_ready is low in BEAT0/BEAT1; req_* inputs are ignored there.
- done and fault never assert in the same cycle.
- Reset mid-operation: the pending beat is dropped, mem_valid clears immediately, and no done is generated.

Test Plan:
- XLEN=32, SB addr 0x1003 data 0xAABBCCDD, mem_ready=1 -> one beat: mem_addr 0x1000, wdata 0xDD000000, wstrb 1000; done 2 cycles after accept.
- SW addr 0x2000 data 0x11223344, mem_ready low for 3 cycles -> mem_valid held 4 cycles with outputs stable (wstrb 1111); exactly one done; req_ready low throughout.
- ALLOW_MISALIGNED=1, SW addr 0x2002 data 0x11223344 -> beat0: 0x2000, 0x33440000, 1100; beat1: 0x2004, 0x00001122, 0011; done after beat1.
- ALLOW_MISALIGNED=1, SH addr 0xFFFFFFFF data 0xBEEF -> beat0: 0xFFFFFFFC, 0xEF000000, 1000; beat1: 0x00000000 (wrap), 0x000000BE, 0001.
- ALLOW_MISALIGNED=0, SW addr 0x2001 -> fault pulse 1 cycle after accept; no mem_valid; no done. Also XLEN=32 with req_type=3 -> fault.
- XLEN=64, SD addr 0x8 data 0x0102030405060708 -> one beat, wstrb 0xFF. Separately, assert rst while in BEAT1 -> mem_valid=0 at once, no done, req_ready=1 after release.
